// File: rtl/tlul_pkg.sv
// TL-UL bus types, widths and the data-integrity helper shared by the SRAM port.
package tlul_pkg;

    localparam int unsigned TlAw              = 32;
    localparam int unsigned TlDw              = 32;
    localparam int unsigned TlDbw             = TlDw / 8;
    localparam int unsigned TlSzw             = 2;
    localparam int unsigned TlAiw             = 8;
    localparam int unsigned TlDiw             = 1;
    localparam int unsigned DataIntgWidth     = 7;
    localparam int unsigned TlSramPortMaxSize = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        ArithmeticData = 3'h2,
        LogicalData    = 3'h3,
        Get            = 3'h4,
        Intent         = 3'h5
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [DataIntgWidth-1:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [DataIntgWidth-1:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic             a_valid;
        tl_a_op_e         a_opcode;
        logic [2:0]       a_param;
        logic [TlSzw-1:0] a_size;
        logic [TlAiw-1:0] a_source;
        logic [TlAw-1:0]  a_address;
        logic [TlDbw-1:0] a_mask;
        logic [TlDw-1:0]  a_data;
        tl_a_user_t       a_user;
        logic             d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic             d_valid;
        tl_d_op_e         d_opcode;
        logic [2:0]       d_param;
        logic [TlSzw-1:0] d_size;
        logic [TlAiw-1:0] d_source;
        logic [TlDiw-1:0] d_sink;
        logic [TlDw-1:0]  d_data;
        tl_d_user_t       d_user;
        logic             d_error;
        logic             a_ready;
    } tl_d2h_t;

    // One outstanding transaction as remembered between A accept and D response.
    typedef struct packed {
        logic             read;
        logic             error;
        logic [TlAiw-1:0] source;
        logic [TlSzw-1:0] size;
    } tl_sram_rsp_t;

    // Interleaved parity: integrity bit k covers every data bit whose index is k mod 7.
    function automatic logic [DataIntgWidth-1:0] tl_data_integ(input logic [TlDw-1:0] data);
        logic [DataIntgWidth-1:0] intg;
        intg = '0;
        for (int unsigned i = 0; i < TlDw; i++) begin
            intg[3'(i % DataIntgWidth)] = intg[3'(i % DataIntgWidth)] ^ data[5'(i)];
        end
        return intg;
    endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO; with Pass set, an empty FIFO forwards write data straight to the read side.
module prim_fifo_sync #(
    parameter int unsigned Width = 16,
    parameter bit          Pass  = 1'b1,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr, rptr;
    logic [CntW-1:0]  cnt;
    logic             empty, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty    = (cnt == '0);
    assign wready_o = (cnt != CntW'(Depth));
    assign rvalid_o = !empty || (Pass && wvalid_i);
    assign rdata_o  = (Pass && empty) ? wdata_i : mem[rptr];
    // A pass-through word consumed in the same cycle is never stored.
    assign push     = wvalid_i && wready_o && !(Pass && empty && rready_i);
    assign pop      = rready_i && !empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            if (push && !pop)      cnt <= cnt + CntW'(1);
            else if (pop && !push) cnt <= cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wdata_i;
    end

endmodule

// File: rtl/tlul_data_integ_enc.sv
// Computes the D-channel data integrity bits for a 32-bit data word.
module tlul_data_integ_enc
    import tlul_pkg::*;
(
    input  logic [TlDw-1:0]          data_i,
    output logic [DataIntgWidth-1:0] data_intg_o
);

    assign data_intg_o = tl_data_integ(data_i);

endmodule

// File: rtl/tlul_sram_port.sv
// Terminal TL-UL device: maps word-aligned TL-UL requests onto a single-port SRAM
// and returns in-order responses, buffering read data against D-channel backpressure.
module tlul_sram_port
    import tlul_pkg::*;
#(
    parameter int unsigned SramAw      = 10,
    parameter int unsigned Outstanding = 2,
    parameter int unsigned SramDw      = 39
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tl_h2d_t           tl_i,
    output tl_d2h_t           tl_o,
    input  logic              error_i,
    output logic              req_o,
    input  logic              gnt_i,
    output logic              we_o,
    output logic [SramAw-1:0] addr_o,
    output logic [SramDw-1:0] wdata_o,
    output logic [SramDw-1:0] wmask_o,
    input  logic              rvalid_i,
    input  logic [SramDw-1:0] rdata_i,
    input  logic [1:0]        rerror_i
);

    localparam int unsigned RdW = SramDw + 1;

    logic a_is_put, a_legal, a_ready, d_valid;
    logic tr_wvalid, tr_wready, tr_rvalid, tr_rready;
    tl_sram_rsp_t tr_wdata, tr_head;
    logic rst_q, rd_wvalid, rd_wready, rd_rvalid, rd_rready;
    logic [RdW-1:0] rd_wdata, rd_head;
    logic [DataIntgWidth-1:0] err_intg;
    logic unused_inputs;

    assign unused_inputs = ^{rerror_i[0], tl_i.a_param};

    // Only full-word-aligned accesses to the mapped range may touch the SRAM.
    assign a_is_put = tl_i.a_opcode inside {PutFullData, PutPartialData};
    assign a_legal  = (a_is_put || (tl_i.a_opcode == Get))
                   && (tl_i.a_address[1:0] == 2'b00)
                   && (tl_i.a_size <= TlSzw'(TlSramPortMaxSize))
                   && !error_i
                   && ((tl_i.a_address >> (SramAw + 2)) == '0);

    assign a_ready = !rst_i && tr_wready && (!a_legal || gnt_i);
    assign req_o   = !rst_i && tl_i.a_valid && a_legal && tr_wready;
    assign we_o    = a_is_put;
    assign addr_o  = tl_i.a_address[SramAw+1:2];
    assign wdata_o = SramDw'({tl_i.a_user.data_intg, tl_i.a_data});
    assign wmask_o = SramDw'({{DataIntgWidth{&tl_i.a_mask}},
                              {8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                              {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}});

    always_comb begin
        tr_wdata        = '0;
        tr_wdata.read   = (tl_i.a_opcode == Get);
        tr_wdata.error  = !a_legal;
        tr_wdata.source = tl_i.a_source;
        tr_wdata.size   = tl_i.a_size;
    end

    assign tr_wvalid = tl_i.a_valid && a_ready;
    assign tr_rready = d_valid && tl_i.d_ready;

    prim_fifo_sync #(
        .Width ($bits(tl_sram_rsp_t)),
        .Pass  (1'b0),
        .Depth (Outstanding)
    ) u_tracker (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wvalid_i (tr_wvalid),
        .wready_o (tr_wready),
        .wdata_i  (tr_wdata),
        .rvalid_o (tr_rvalid),
        .rready_i (tr_rready),
        .rdata_o  (tr_head)
    );

    // A read response landing in the cycle after reset belongs to a dropped request.
    always_ff @(posedge clk_i) begin
        rst_q <= rst_i;
    end

    assign rd_wvalid = rvalid_i && !rst_i && !rst_q && rd_wready;
    assign rd_wdata  = {rerror_i[1], rdata_i};
    assign rd_rready = tr_rready && tr_head.read && !tr_head.error;

    prim_fifo_sync #(
        .Width (RdW),
        .Pass  (1'b1),
        .Depth (Outstanding)
    ) u_rdata (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wvalid_i (rd_wvalid),
        .wready_o (rd_wready),
        .wdata_i  (rd_wdata),
        .rvalid_o (rd_rvalid),
        .rready_i (rd_rready),
        .rdata_o  (rd_head)
    );

    tlul_data_integ_enc u_err_intg (
        .data_i      ({TlDw{1'b1}}),
        .data_intg_o (err_intg)
    );

    assign d_valid = !rst_i && tr_rvalid && (tr_head.error || !tr_head.read || rd_rvalid);

    // D channel reflects the tracker head; error beats win over read data.
    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = d_valid;
        tl_o.d_opcode = tr_head.read ? AccessAckData : AccessAck;
        tl_o.d_size   = tr_head.size;
        tl_o.d_source = tr_head.source;
        if (tr_head.error) begin
            tl_o.d_error            = 1'b1;
            tl_o.d_data             = '1;
            tl_o.d_user.data_intg   = err_intg;
        end else if (tr_head.read) begin
            tl_o.d_error            = rd_head[SramDw];
            tl_o.d_data             = rd_head[TlDw-1:0];
            tl_o.d_user.data_intg   = rd_head[SramDw-1:TlDw];
        end
    end

endmodule

// File: tb/tb_tlul_sram_port.sv
// Directed bench for tlul_sram_port: the bench plays the SRAM cycle by cycle.
module tb_tlul_sram_port;
    import tlul_pkg::*;

    logic        clk;
    logic        rst_i;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        error_i;
    logic        req_o;
    logic        gnt_i;
    logic        we_o;
    logic [9:0]  addr_o;
    logic [38:0] wdata_o;
    logic [38:0] wmask_o;
    logic        rvalid_i;
    logic [38:0] rdata_i;
    logic [1:0]  rerror_i;

    int checks = 0;
    int errors = 0;

    tlul_sram_port #(
        .SramAw      (10),
        .Outstanding (2),
        .SramDw      (39)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .tl_i     (tl_i),
        .tl_o     (tl_o),
        .error_i  (error_i),
        .req_o    (req_o),
        .gnt_i    (gnt_i),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .wmask_o  (wmask_o),
        .rvalid_i (rvalid_i),
        .rdata_i  (rdata_i),
        .rerror_i (rerror_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle();
        tl_i         = '0;
        tl_i.d_ready = 1'b1;
        error_i      = 1'b0;
        gnt_i        = 1'b0;
        rvalid_i     = 1'b0;
        rdata_i      = '0;
        rerror_i     = '0;
    endtask

    task automatic put_a(input tl_a_op_e op, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [7:0] src);
        tl_i.a_valid          = 1'b1;
        tl_i.a_opcode         = op;
        tl_i.a_size           = 2'd2;
        tl_i.a_source         = src;
        tl_i.a_address        = addr;
        tl_i.a_mask           = mask;
        tl_i.a_data           = data;
        tl_i.a_user.data_intg = 7'h11;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        repeat (3) next_cycle();

        // Reset: nothing accepted or issued even with a pending, grantable Get
        put_a(Get, 32'h10, 4'hF, 32'h0, 8'h01);
        gnt_i = 1'b1;
        #1;
        chk("rst_a_ready", 64'(tl_o.a_ready), 64'h0);
        chk("rst_req", 64'(req_o), 64'h0);
        chk("rst_d_valid", 64'(tl_o.d_valid), 64'h0);

        next_cycle();
        rst_i = 1'b0;
        idle();
        #1;
        chk("post_rst_d_valid", 64'(tl_o.d_valid), 64'h0);

        // Get 0x10 -> word 4, data returned the cycle after grant
        next_cycle();
        put_a(Get, 32'h10, 4'hF, 32'h0, 8'h03);
        gnt_i = 1'b1;
        #1;
        chk("get_req", 64'(req_o), 64'h1);
        chk("get_we", 64'(we_o), 64'h0);
        chk("get_addr", 64'(addr_o), 64'h4);
        chk("get_a_ready", 64'(tl_o.a_ready), 64'h1);
        next_cycle();
        idle();
        rvalid_i = 1'b1;
        rdata_i  = 39'h55_DEADBEEF;
        #1;
        chk("get_d_valid", 64'(tl_o.d_valid), 64'h1);
        chk("get_d_opcode", 64'(tl_o.d_opcode), 64'h1);
        chk("get_d_data", 64'(tl_o.d_data), 64'hDEADBEEF);
        chk("get_d_intg", 64'(tl_o.d_user.data_intg), 64'h55);
        chk("get_d_error", 64'(tl_o.d_error), 64'h0);
        chk("get_d_source", 64'(tl_o.d_source), 64'h3);
        next_cycle();
        idle();
        #1;
        chk("get_done", 64'(tl_o.d_valid), 64'h0);

        // PutPartialData mask 0011: low two bytes written, integrity bits held
        put_a(PutPartialData, 32'h20, 4'b0011, 32'h1234ABCD, 8'h07);
        gnt_i = 1'b1;
        #1;
        chk("pp_req", 64'(req_o), 64'h1);
        chk("pp_we", 64'(we_o), 64'h1);
        chk("pp_addr", 64'(addr_o), 64'h8);
        chk("pp_wdata", 64'(wdata_o), 64'h11_1234ABCD);
        chk("pp_wmask", 64'(wmask_o), 64'h00_0000FFFF);
        next_cycle();
        idle();
        #1;
        chk("pp_d_valid", 64'(tl_o.d_valid), 64'h1);
        chk("pp_d_opcode", 64'(tl_o.d_opcode), 64'h0);
        chk("pp_d_error", 64'(tl_o.d_error), 64'h0);
        chk("pp_d_data", 64'(tl_o.d_data), 64'h0);
        chk("pp_d_source", 64'(tl_o.d_source), 64'h7);

        // PutFullData: full mask enables integrity bits too
        next_cycle();
        put_a(PutFullData, 32'h24, 4'hF, 32'hCAFEF00D, 8'h08);
        gnt_i = 1'b1;
        #1;
        chk("pf_wmask", 64'(wmask_o), 64'h7F_FFFFFFFF);
        chk("pf_addr", 64'(addr_o), 64'h9);
        next_cycle();
        idle();
        #1;
        chk("pf_d_valid", 64'(tl_o.d_valid), 64'h1);

        // Upstream error on Get: no SRAM access, errored AccessAckData
        next_cycle();
        put_a(Get, 32'h30, 4'hF, 32'h0, 8'h09);
        error_i = 1'b1;
        #1;
        chk("err_req", 64'(req_o), 64'h0);
        chk("err_a_ready", 64'(tl_o.a_ready), 64'h1);
        next_cycle();
        idle();
        #1;
        chk("err_d_valid", 64'(tl_o.d_valid), 64'h1);
        chk("err_d_opcode", 64'(tl_o.d_opcode), 64'h1);
        chk("err_d_error", 64'(tl_o.d_error), 64'h1);
        chk("err_d_data", 64'(tl_o.d_data), 64'hFFFFFFFF);
        chk("err_d_intg", 64'(tl_o.d_user.data_intg), 64'h0F);

        // Address just past the SRAM: illegal, AccessAck with error
        next_cycle();
        put_a(PutFullData, 32'h1000, 4'hF, 32'h0, 8'h0A);
        #1;
        chk("oob_req", 64'(req_o), 64'h0);
        chk("oob_a_ready", 64'(tl_o.a_ready), 64'h1);
        next_cycle();
        idle();
        #1;
        chk("oob_d_opcode", 64'(tl_o.d_opcode), 64'h0);
        chk("oob_d_error", 64'(tl_o.d_error), 64'h1);

        // Last word of the SRAM is legal
        next_cycle();
        put_a(Get, 32'hFFC, 4'hF, 32'h0, 8'h0B);
        gnt_i = 1'b1;
        #1;
        chk("top_req", 64'(req_o), 64'h1);
        chk("top_addr", 64'(addr_o), 64'h3FF);
        next_cycle();
        idle();
        rvalid_i = 1'b1;
        rdata_i  = 39'h00_00000042;
        #1;
        chk("top_d_error", 64'(tl_o.d_error), 64'h0);
        chk("top_d_data", 64'(tl_o.d_data), 64'h42);

        // Three Gets under backpressure with two outstanding slots
        next_cycle();
        idle();
        tl_i.d_ready = 1'b0;
        put_a(Get, 32'h40, 4'hF, 32'h0, 8'h01);
        gnt_i = 1'b1;
        #1;
        chk("bp1_a_ready", 64'(tl_o.a_ready), 64'h1);
        next_cycle();
        put_a(Get, 32'h44, 4'hF, 32'h0, 8'h02);
        rvalid_i = 1'b1;
        rdata_i  = 39'h01_AAAA0001;
        #1;
        chk("bp2_a_ready", 64'(tl_o.a_ready), 64'h1);
        chk("bp2_d_valid", 64'(tl_o.d_valid), 64'h1);
        chk("bp2_d_data", 64'(tl_o.d_data), 64'hAAAA0001);
        next_cycle();
        put_a(Get, 32'h48, 4'hF, 32'h0, 8'h03);
        rdata_i = 39'h02_BBBB0002;
        #1;
        chk("bp3_a_ready", 64'(tl_o.a_ready), 64'h0);
        chk("bp3_req", 64'(req_o), 64'h0);
        chk("bp3_d_data", 64'(tl_o.d_data), 64'hAAAA0001);
        next_cycle();
        rvalid_i     = 1'b0;
        tl_i.d_ready = 1'b1;
        #1;
        chk("bp4_a_ready", 64'(tl_o.a_ready), 64'h0);
        chk("bp4_d_source", 64'(tl_o.d_source), 64'h1);
        chk("bp4_d_data", 64'(tl_o.d_data), 64'hAAAA0001);
        next_cycle();
        #1;
        chk("bp5_a_ready", 64'(tl_o.a_ready), 64'h1);
        chk("bp5_req", 64'(req_o), 64'h1);
        chk("bp5_addr", 64'(addr_o), 64'h12);
        chk("bp5_d_source", 64'(tl_o.d_source), 64'h2);
        chk("bp5_d_data", 64'(tl_o.d_data), 64'hBBBB0002);
        next_cycle();
        idle();
        rvalid_i = 1'b1;
        rdata_i  = 39'h03_CCCC0003;
        #1;
        chk("bp6_d_source", 64'(tl_o.d_source), 64'h3);
        chk("bp6_d_data", 64'(tl_o.d_data), 64'hCCCC0003);
        chk("bp6_d_intg", 64'(tl_o.d_user.data_intg), 64'h03);
        next_cycle();
        idle();
        #1;
        chk("bp_done", 64'(tl_o.d_valid), 64'h0);

        // Uncorrectable vs corrected SRAM errors
        put_a(Get, 32'h50, 4'hF, 32'h0, 8'h04);
        gnt_i = 1'b1;
        next_cycle();
        idle();
        rvalid_i = 1'b1;
        rdata_i  = 39'h00_12345678;
        rerror_i = 2'b10;
        #1;
        chk("ue_d_error", 64'(tl_o.d_error), 64'h1);
        chk("ue_d_data", 64'(tl_o.d_data), 64'h12345678);
        next_cycle();
        idle();
        put_a(Get, 32'h54, 4'hF, 32'h0, 8'h05);
        gnt_i = 1'b1;
        next_cycle();
        idle();
        rvalid_i = 1'b1;
        rdata_i  = 39'h00_87654321;
        rerror_i = 2'b01;
        #1;
        chk("ce_d_valid", 64'(tl_o.d_valid), 64'h1);
        chk("ce_d_error", 64'(tl_o.d_error), 64'h0);

        // Reset with two reads outstanding drops them; stale rvalid is ignored
        next_cycle();
        idle();
        tl_i.d_ready = 1'b0;
        put_a(Get, 32'h60, 4'hF, 32'h0, 8'h06);
        gnt_i = 1'b1;
        next_cycle();
        put_a(Get, 32'h64, 4'hF, 32'h0, 8'h07);
        rvalid_i = 1'b1;
        rdata_i  = 39'h00_11111111;
        #1;
        chk("rr_pre_d_valid", 64'(tl_o.d_valid), 64'h1);
        next_cycle();
        idle();
        tl_i.d_ready = 1'b0;
        rvalid_i     = 1'b1;
        rdata_i      = 39'h00_22222222;
        rst_i        = 1'b1;
        #1;
        chk("rr_in_rst_d_valid", 64'(tl_o.d_valid), 64'h0);
        chk("rr_in_rst_a_ready", 64'(tl_o.a_ready), 64'h0);
        next_cycle();
        rst_i = 1'b0;
        idle();
        rvalid_i = 1'b1;
        rdata_i  = 39'h7E_0BAD0BAD;
        #1;
        chk("rr_after_d_valid", 64'(tl_o.d_valid), 64'h0);
        next_cycle();
        idle();
        put_a(Get, 32'h68, 4'hF, 32'h0, 8'h08);
        gnt_i = 1'b1;
        #1;
        chk("rr_new_a_ready", 64'(tl_o.a_ready), 64'h1);
        chk("rr_new_d_valid", 64'(tl_o.d_valid), 64'h0);
        next_cycle();
        idle();
        rvalid_i = 1'b1;
        rdata_i  = 39'h0A_600D600D;
        #1;
        chk("rr_new_rsp_valid", 64'(tl_o.d_valid), 64'h1);
        chk("rr_new_rsp_data", 64'(tl_o.d_data), 64'h600D600D);
        chk("rr_new_rsp_source", 64'(tl_o.d_source), 64'h8);
        next_cycle();
        idle();
        #1;
        chk("rr_done", 64'(tl_o.d_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
